chunked_adder: RTL and testbench
================================

# chunked_adder

Parametrised, multi-cycle successor to the 16-bit ripple full adder. It computes `a + b + cin`, or `a - b`, one CHUNK-bit slice per clock, LSB slice first, and carries the result between slices in a register. Valid/ready handshakes on both the operand and result sides let it sit between the d16i register-read stage and writeback as a low-area ALU adder. Width and slice size are generic, so the same block serves 8/16/32-bit datapaths.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width in bits.
- `CHUNK`, 4: bits added per cycle. Must divide `WIDTH`. N = `WIDTH`/`CHUNK` slices.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: operands valid.
- `in_ready`, out, 1: block can accept operands.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `cin`, in, 1: carry in. Ignored when `sub`=1.
- `sub`, in, 1: 0 = `a+b+cin`; 1 = `a+~b+1`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts result.
- `z`, out, WIDTH: sum.
- `cout`, out, 1: carry out of MSB. When `sub`=1, 1 means no borrow.
- `zero`, `neg`, `ovf`, out, 1 each: flags, present only with `CHUNKED_ADDER_FLAGS_EN`.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `a`; latch `b`, or `~b` when `sub`=1; set carry reg = `sub ? 1 : cin`; clear slice counter k; go to CALC.
- CALC:
  - Each cycle, add slice k of A, slice k of B and the carry reg.
  - Write the CHUNK-bit sum into `z[k*CHUNK +: CHUNK]`; update the carry reg; k++.
  - After slice N-1: `cout` = final carry; go to DONE.
- DONE:
  - `out_valid`=1; `z`, `cout` and flags held stable.
  - On `out_valid & out_ready`: go to IDLE.
- `in_ready`=0 in CALC and DONE. There is no overlap of operations.
- Arithmetic is modulo 2^WIDTH. Bits of `z` above slice k hold their previous values until written. Consumers use `z` only while `out_valid` is high.
- Reset, at any state including mid-CALC or DONE: go to IDLE and discard the operation. A new result is produced only after a new handshake.
- Reset values: `in_ready`=0 while `rst` is high, 1 in the first cycle after. `out_valid`=0, `z`=0, `cout`=0; `zero`/`neg`/`ovf`=0.

## Timing
- Input handshake at edge E0. Slice k is written at edge E(k+1). `out_valid` rises after edge EN, giving latency N cycles.
- With `CHUNK`=`WIDTH`: N=1, latency 1.
- Output handshake at edge Ed. `in_ready`=1 in the cycle after Ed. The next accept is earliest at edge Ed+1, so throughput is at most one op per N+2 cycles.
- `in_valid` while `in_ready`=0 is ignored. The producer holds its operands until the handshake.
- `out_ready` asserted before `out_valid` has no effect.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `in_valid`/`out_ready`.

## Configuration
- `CHUNKED_ADDER_FLAGS_EN` defined:
  - `zero`=(`z`==0).
  - `neg`=`z[WIDTH-1]`.
  - `ovf`= carry into MSB XOR `cout` (signed overflow), computed from the final slice.
  - All three update on entry to DONE and hold with `z`.
- Undefined: the flag ports and their logic are absent. Everything else is identical.

## Test plan
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles `out_valid`=1, z=0x0000, cout=1, zero=1.
- a=0x000F, b=0x00F0, cin=1 -> z=0x0100, cout=0. Separately, a=0x7FFF, b=0x0001 -> z=0x8000, ovf=1, neg=1.
- sub=1, a=0x0005, b=0x0007, cin=1 -> z=0xFFFE, cout=0, neg=1, ovf=0. Confirms `cin` is ignored.
- Back-pressure: hold `out_ready`=0 for 3 cycles in DONE -> `z`/`out_valid` stable, `in_ready`=0, and a pulse on `in_valid` is ignored. Release -> `in_ready`=1 the next cycle.
- `rst`=1 two cycles after accept (mid-CALC) -> next cycle `out_valid`=0, z=0; after reset drops, `in_ready`=1. A new op completes correctly.
- CHUNK=16 build: a=0x1234, b=0x4321 -> `out_valid` one cycle after accept, z=0x5555, cout=0.

Source files
------------

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// Optional flag signals (zero/neg/ovf) exist only when CHUNKED_ADDER_FLAGS_EN is defined.
interface chunked_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             cout;
`ifdef CHUNKED_ADDER_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  // Adder side: consumes operands, produces the result.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
`ifdef CHUNKED_ADDER_FLAGS_EN
    output zero, neg, ovf,
`endif
    output in_ready, out_valid, z, cout
  );

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
`ifdef CHUNKED_ADDER_FLAGS_EN
    input  zero, neg, ovf,
`endif
    input  in_ready, out_valid, z, cout
  );
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle a+b+cin / a-b adder, CHUNK bits per clock, LSB slice first.
// Optional build macro CHUNKED_ADDER_FLAGS_EN adds zero/neg/ovf result flags.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for operands (in_ready=1 once reset is released)
// CALC   | adding slice k each cycle, carry held between slices
// DONE   | result valid, held until out_ready
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic            clk,
  input logic            rst,
  chunked_adder_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
`ifdef CHUNKED_ADDER_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice_sum;
  logic             last_slice;

  // Select slice k of the latched operands and add it with the running carry.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
    slice_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    last_slice = (k_q == KW'(N - 1));
  end

  // Next-state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef CHUNKED_ADDER_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          // Subtraction is a + ~b + 1, so the inversion happens once at accept.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          k_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) begin
            z_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
          end
        end
        carry_d = slice_sum[CHUNK];
        k_d     = k_q + 1'b1;
        if (last_slice) begin
          cout_d  = slice_sum[CHUNK];
          state_d = S_DONE;
`ifdef CHUNKED_ADDER_FLAGS_EN
          zero_d  = (z_d == '0);
          neg_d   = z_d[WIDTH-1];
          // Carry into the MSB is recovered from the MSB sum bit of the final slice.
          ovf_d   = (a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_sum[CHUNK-1]) ^ slice_sum[CHUNK];
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // in_ready is held low while reset is asserted so nothing is accepted during reset.
  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.z         = z_q;
  assign bus.cout      = cout_q;
`ifdef CHUNKED_ADDER_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: WIDTH=16/CHUNK=4 main instance plus a CHUNK=16 instance.
module tb_chunked_adder;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  typedef struct packed {
    logic [W-1:0] z;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(W)) ifc ();
  chunked_adder_if #(.WIDTH(W)) ifc1 ();

  chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  chunked_adder #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1)
  );

  // Whole-word reference: two's-complement add of a and (b or ~b) with carry-in.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0]   s;
    logic [W-1:0] bo;
    logic         c0;
    res_t         r;
    bo = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    s  = {1'b0, a} + {1'b0, bo} + {{W{1'b0}}, c0};
    r.z    = s[W-1:0];
    r.cout = s[W];
    r.zero = (r.z == '0);
    r.neg  = r.z[W-1];
    r.ovf  = (a[W-1] == bo[W-1]) && (r.z[W-1] != a[W-1]);
    return r;
  endfunction

  // Launch one op on the main instance; returns at the negedge where out_valid is seen
  // (result left in DONE). lat = cycles from accept to out_valid, -1 on timeout.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tsub, output res_t got, output int lat);
    int n;
    @(negedge clk);
    ifc.a = ta; ifc.b = tb_v; ifc.cin = tcin; ifc.sub = tsub;
    ifc.in_valid = 1'b1;
    n = 0;
    while (!ifc.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    got = '0;
    if (!ifc.in_ready) begin
      ifc.in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!ifc.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ifc.out_valid) lat = -1;
    got.z    = ifc.z;
    got.cout = ifc.cout;
`ifdef CHUNKED_ADDER_FLAGS_EN
    got.zero = ifc.zero;
    got.neg  = ifc.neg;
    got.ovf  = ifc.ovf;
`endif
  endtask

  // Complete the output handshake; returns just after edge Ed.
  task automatic release_out();
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0; ifc.sub = 1'b0;
    ifc1.in_valid = 1'b0; ifc1.out_ready = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.cin = 1'b0; ifc1.sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.z !== '0 || ifc.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b z=%h cout=%b required 0 0 0000 0",
               ifc.in_ready, ifc.out_valid, ifc.z, ifc.cout);
    end
`ifdef CHUNKED_ADDER_FLAGS_EN
    checks++;
    if ({ifc.zero, ifc.neg, ifc.ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000", {ifc.zero, ifc.neg, ifc.ovf});
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", ifc.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{16'hFFFF, 16'h000F, 16'h7FFF, 16'h0005};
    logic [W-1:0] vb [4] = '{16'h0001, 16'h00F0, 16'h0001, 16'h0007};
    logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic         vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    res_t exp_r, got;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      exp_r = model(va[i], vb[i], vc[i], vs[i]);
      run_op(va[i], vb[i], vc[i], vs[i], got, lat);
      checks++;
      if (lat !== N) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, N);
      end
      checks++;
      if (got.z !== exp_r.z || got.cout !== exp_r.cout) begin
        errors++;
        $display("FAIL directed_result[%0d]: z=%h cout=%b required z=%h cout=%b",
                 i, got.z, got.cout, exp_r.z, exp_r.cout);
      end
`ifdef CHUNKED_ADDER_FLAGS_EN
      checks++;
      if ({got.zero, got.neg, got.ovf} !== {exp_r.zero, exp_r.neg, exp_r.ovf}) begin
        errors++;
        $display("FAIL directed_flags[%0d]: zno=%b required %b", i,
                 {got.zero, got.neg, got.ovf}, {exp_r.zero, exp_r.neg, exp_r.ovf});
      end
`endif
      release_out();
    end
  endtask

  task automatic test_random();
    res_t         exp_r, got;
    int           lat;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ((i % 7) == 0) ra = 16'hFFFF;
      if ((i % 11) == 0) rb = 16'h8000;
      rc = 1'($urandom);
      rs = 1'($urandom);
      exp_r = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, got, lat);
      checks++;
      if (lat !== N || got.z !== exp_r.z || got.cout !== exp_r.cout) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b sub=%b: lat=%0d z=%h cout=%b required lat=%0d z=%h cout=%b",
                 i, ra, rb, rc, rs, lat, got.z, got.cout, N, exp_r.z, exp_r.cout);
      end
`ifdef CHUNKED_ADDER_FLAGS_EN
      checks++;
      if ({got.zero, got.neg, got.ovf} !== {exp_r.zero, exp_r.neg, exp_r.ovf}) begin
        errors++;
        $display("FAIL random_flags[%0d]: zno=%b required %b", i,
                 {got.zero, got.neg, got.ovf}, {exp_r.zero, exp_r.neg, exp_r.ovf});
      end
`endif
      release_out();
    end
  endtask

  task automatic test_back_pressure();
    res_t exp_r, got;
    int   lat;
    exp_r = model(16'h1234, 16'h0F0F, 1'b1, 1'b0);
    run_op(16'h1234, 16'h0F0F, 1'b1, 1'b0, got, lat);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        ifc.a = 16'hFFFF; ifc.b = 16'hFFFF; ifc.sub = 1'b1;
        ifc.in_valid = 1'b1;
      end else begin
        ifc.in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.z !== exp_r.z || ifc.cout !== exp_r.cout) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b z=%h cout=%b required 1 0 %h %b",
                 i, ifc.out_valid, ifc.in_ready, ifc.z, ifc.cout, exp_r.z, exp_r.cout);
      end
    end
    ifc.in_valid = 1'b0;
    release_out();
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", ifc.in_ready, ifc.out_valid);
    end
    repeat (N + 1) @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_pulse_ignored: out_valid=%b required 0", ifc.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    res_t exp_r, got;
    int   lat;
    @(negedge clk);
    ifc.a = 16'h1111; ifc.b = 16'h2222; ifc.cin = 1'b0; ifc.sub = 1'b0;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.z !== '0 || ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_reset: out_valid=%b z=%h in_ready=%b required 0 0000 0",
               ifc.out_valid, ifc.z, ifc.in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midcalc_ready: in_ready=%b required 1", ifc.in_ready);
    end
    repeat (N + 1) @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_discard: out_valid=%b required 0", ifc.out_valid);
    end
    exp_r = model(16'hA5A5, 16'h5A5B, 1'b0, 1'b1);
    run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b1, got, lat);
    checks++;
    if (lat !== N || got.z !== exp_r.z || got.cout !== exp_r.cout) begin
      errors++;
      $display("FAIL midcalc_next_op: lat=%0d z=%h cout=%b required %0d %h %b",
               lat, got.z, got.cout, N, exp_r.z, exp_r.cout);
    end
    release_out();
  endtask

  task automatic test_single_chunk();
    res_t exp_r;
    int   lat;
    logic [W-1:0] ta, tbv;
    for (int i = 0; i < 4; i++) begin
      ta  = (i == 0) ? 16'h1234 : W'($urandom);
      tbv = (i == 0) ? 16'h4321 : W'($urandom);
      exp_r = model(ta, tbv, 1'b0, 1'(i % 2));
      @(negedge clk);
      ifc1.a = ta; ifc1.b = tbv; ifc1.cin = 1'b0; ifc1.sub = 1'(i % 2);
      ifc1.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc1.in_valid = 1'b0;
      lat = 0;
      while (!ifc1.out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 1 || ifc1.z !== exp_r.z || ifc1.cout !== exp_r.cout) begin
        errors++;
        $display("FAIL chunk16[%0d]: lat=%0d z=%h cout=%b required 1 %h %b",
                 i, lat, ifc1.z, ifc1.cout, exp_r.z, exp_r.cout);
      end
      ifc1.out_ready = 1'b1;
      @(posedge clk);
      #1 ifc1.out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_mid_reset();
    test_single_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
